// File: rtl/ysyx_lsu_pkg.sv
// Shared types and constants for the EXU-side load/store unit.
package ysyx_lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA,
        WREQ,
        WRESP,
        DONE
    } lsu_state_e;

    // funct3 access sizes; any other encoding behaves as a word access
    localparam logic [2:0] LSU_B  = 3'd0;
    localparam logic [2:0] LSU_H  = 3'd1;
    localparam logic [2:0] LSU_W  = 3'd2;
    localparam logic [2:0] LSU_BU = 3'd4;
    localparam logic [2:0] LSU_HU = 3'd5;

    // AXI response codes
    localparam logic [1:0] OKAY   = 2'd0;
    localparam logic [1:0] SLVERR = 2'd2;

    // Natural-alignment test for an access of the given size at byte offset off
    function automatic logic lsu_misaligned(input logic [2:0] fn, input logic [1:0] off);
        case (fn)
            LSU_B, LSU_BU: return 1'b0;
            LSU_H, LSU_HU: return off[0];
            default:       return off != 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_lsu_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
module ysyx_lsu_align
    import ysyx_lsu_pkg::*;
#(
    parameter int BIT_W = 32
) (
    input  logic [2:0]         fn,
    input  logic [1:0]         off,
    input  logic [BIT_W-1:0]   st_data,
    output logic [BIT_W-1:0]   st_lanes,
    output logic [BIT_W/8-1:0] st_strb,
    input  logic [BIT_W-1:0]   ld_word,
    output logic [BIT_W-1:0]   ld_data
);

    localparam int SW = BIT_W / 8;

    logic [SW-1:0]    base_strb;
    logic [BIT_W-1:0] shifted;

    // Store: move low-aligned data and strobes up to the addressed byte; high lanes fall off
    always_comb begin
        base_strb = '1;
        case (fn)
            LSU_B, LSU_BU: base_strb = SW'(1);
            LSU_H, LSU_HU: base_strb = SW'(3);
            default:       base_strb = '1;
        endcase
        st_strb  = base_strb << off;
        st_lanes = st_data << {off, 3'b000};
    end

    // Load: bring the addressed byte down to bit 0, then extend to full width
    always_comb begin
        shifted = ld_word >> {off, 3'b000};
        ld_data = shifted;
        case (fn)
            LSU_B:   ld_data = {{(BIT_W-8){shifted[7]}}, shifted[7:0]};
            LSU_H:   ld_data = {{(BIT_W-16){shifted[15]}}, shifted[15:0]};
            LSU_BU:  ld_data = {{(BIT_W-8){1'b0}}, shifted[7:0]};
            LSU_HU:  ld_data = {{(BIT_W-16){1'b0}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_lsu_ctrl.sv
// EXU load/store request to AXI4-Lite master bridge.
// Optional: define YSYX_LSU_FAULT_EN to report bus errors and to short-circuit
// misaligned requests with a fault instead of issuing them.
module ysyx_lsu_ctrl
    import ysyx_lsu_pkg::*;
#(
    parameter int BIT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lsu_avalid,
    input  logic               lsu_ren,
    input  logic               lsu_wen,
    input  logic [BIT_W-1:0]   lsu_addr,
    input  logic [BIT_W-1:0]   lsu_wdata,
    input  logic [3:0]         lsu_fn,
    output logic [BIT_W-1:0]   lsu_rdata,
    output logic               lsu_rvalid,
    output logic               lsu_wready,
    output logic               lsu_fault,
    output logic [BIT_W-1:0]   araddr,
    output logic               arvalid,
    input  logic               arready,
    input  logic [BIT_W-1:0]   rdata,
    input  logic [1:0]         rresp,
    input  logic               rvalid,
    output logic               rready,
    output logic [BIT_W-1:0]   awaddr,
    output logic               awvalid,
    input  logic               awready,
    output logic [BIT_W-1:0]   wdata,
    output logic [BIT_W/8-1:0] wstrb,
    output logic               wvalid,
    input  logic               wready,
    input  logic [1:0]         bresp,
    input  logic               bvalid,
    output logic               bready
);

    lsu_state_e state, state_nxt;

    logic [BIT_W-1:0]   addr_q;
    logic [BIT_W-1:0]   wdata_q;
    logic [2:0]         fn_q;
    logic               load_q;
    logic               fault_q;
    logic               aw_done;
    logic               w_done;
    logic [BIT_W-1:0]   ld_data;
    logic [BIT_W-1:0]   st_lanes;
    logic [BIT_W/8-1:0] st_strb;
    logic               accept_ld;
    logic               accept_st;
    logic               req_skip;
    logic               rd_err;
    logic               wr_err;
    logic               unused_fn_msb;

    assign accept_ld     = lsu_avalid & lsu_ren;
    assign accept_st     = lsu_avalid & lsu_wen & ~lsu_ren;
    assign unused_fn_msb = lsu_fn[3];

`ifdef YSYX_LSU_FAULT_EN
    assign req_skip = lsu_misaligned(lsu_fn[2:0], lsu_addr[1:0]);
    assign rd_err   = rresp != OKAY;
    assign wr_err   = bresp != OKAY;
`else
    logic unused_resp;
    assign unused_resp = ^{rresp, bresp};
    assign req_skip    = 1'b0;
    assign rd_err      = 1'b0;
    assign wr_err      = 1'b0;
`endif

    ysyx_lsu_align #(.BIT_W(BIT_W)) u_align (
        .fn       (fn_q),
        .off      (addr_q[1:0]),
        .st_data  (wdata_q),
        .st_lanes (st_lanes),
        .st_strb  (st_strb),
        .ld_word  (rdata),
        .ld_data  (ld_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state and bus/response outputs, all decoded from the current state
    always_comb begin
        state_nxt  = state;
        arvalid    = 1'b0;
        araddr     = '0;
        rready     = 1'b0;
        awvalid    = 1'b0;
        awaddr     = '0;
        wvalid     = 1'b0;
        wdata      = '0;
        wstrb      = '0;
        bready     = 1'b0;
        lsu_rvalid = 1'b0;
        lsu_wready = 1'b0;
        case (state)
            IDLE: begin
                if (accept_ld)      state_nxt = req_skip ? DONE : RADDR;
                else if (accept_st) state_nxt = req_skip ? DONE : WREQ;
            end
            RADDR: begin
                arvalid = 1'b1;
                araddr  = addr_q;
                if (arready) state_nxt = RDATA;
            end
            RDATA: begin
                rready = 1'b1;
                if (rvalid) state_nxt = DONE;
            end
            WREQ: begin
                // AW and W retire independently; leave once both have been taken
                awvalid = ~aw_done;
                awaddr  = addr_q;
                wvalid  = ~w_done;
                wdata   = st_lanes;
                wstrb   = st_strb;
                if ((aw_done | awready) & (w_done | wready)) state_nxt = WRESP;
            end
            WRESP: begin
                bready = 1'b1;
                if (bvalid) state_nxt = DONE;
            end
            DONE: begin
                // EXU still holds avalid here, so no request is sampled
                lsu_rvalid = load_q;
                lsu_wready = ~load_q;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign lsu_fault = (state == DONE) & fault_q;

    // Request capture, write-channel bookkeeping and load-result register
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            fn_q      <= '0;
            load_q    <= 1'b0;
            fault_q   <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            lsu_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    fault_q <= req_skip;
                    if (accept_ld | accept_st) begin
                        addr_q <= lsu_addr;
                        fn_q   <= lsu_fn[2:0];
                        load_q <= lsu_ren;
                    end
                    if (accept_st) wdata_q <= lsu_wdata;
                end
                RDATA: begin
                    if (rvalid) begin
                        lsu_rdata <= ld_data;
                        fault_q   <= rd_err;
                    end
                end
                WREQ: begin
                    if (awready) aw_done <= 1'b1;
                    if (wready)  w_done  <= 1'b1;
                end
                WRESP: begin
                    if (bvalid) fault_q <= wr_err;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_lsu_ctrl.sv
// Randomized bench for ysyx_lsu_ctrl with an arithmetic reference model and an
// in-bench AXI4-Lite slave. Fault expectations follow YSYX_LSU_FAULT_EN.
module tb_ysyx_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_avalid, lsu_ren, lsu_wen;
    logic [31:0] lsu_addr, lsu_wdata;
    logic [3:0]  lsu_fn;
    logic [31:0] lsu_rdata;
    logic        lsu_rvalid, lsu_wready, lsu_fault;
    logic [31:0] araddr;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    logic [31:0] awaddr;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [31:0] last_rdata;

`ifdef YSYX_LSU_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    ysyx_lsu_ctrl #(.BIT_W(32)) dut (
        .clk(clk), .rst(rst),
        .lsu_avalid(lsu_avalid), .lsu_ren(lsu_ren), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_fn(lsu_fn),
        .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid), .lsu_wready(lsu_wready),
        .lsu_fault(lsu_fault),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned size_of(input logic [3:0] fn);
        case (fn[2:0])
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] a,
                                               input logic [3:0] fn);
        int unsigned off;
        logic [31:0] s, v;
        off = 32'(a[1:0]);
        s = word >> (8 * off);
        case (fn[2:0])
            3'd0: begin v = s % 256;   if (v >= 128)   v = v + 32'hFFFF_FF00; end
            3'd1: begin v = s % 65536; if (v >= 32768) v = v + 32'hFFFF_0000; end
            3'd4: v = s % 256;
            3'd5: v = s % 65536;
            default: v = s;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [31:0] a);
        int unsigned off;
        off = 32'(a[1:0]);
        return wd * (32'd1 << (8 * off));
    endfunction

    function automatic logic [3:0] model_strb(input logic [31:0] a, input logic [3:0] fn);
        logic [31:0] m;
        m = ((32'd1 << size_of(fn)) - 32'd1) << 32'(a[1:0]);
        return m[3:0];
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic check_all_zero(input string tag);
        check({tag, "_rdata"}, lsu_rdata, 32'd0);
        check({tag, "_pulses"}, 32'({lsu_rvalid, lsu_wready, lsu_fault}), 32'd0);
        check({tag, "_valids"}, 32'({arvalid, awvalid, wvalid}), 32'd0);
        check({tag, "_readies"}, 32'({rready, bready}), 32'd0);
        check({tag, "_araddr"}, araddr, 32'd0);
        check({tag, "_awaddr"}, awaddr, 32'd0);
        check({tag, "_wdata"}, wdata, 32'd0);
        check({tag, "_wstrb"}, 32'(wstrb), 32'd0);
    endtask

    task automatic idle(input int unsigned n);
        lsu_avalid = 1'b0;
        lsu_ren    = 1'b0;
        lsu_wen    = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            check("idle_quiet", 32'({lsu_rvalid, lsu_wready, arvalid, awvalid, wvalid}), 32'd0);
        end
    endtask

    // mode 0: random slave readiness/latency; 1: zero-wait slave; 2: awready 3 cycles after W
    task automatic do_txn(input bit ld, input bit st, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] fn, input logic [31:0] word, input logic [1:0] resp,
                          input int unsigned mode);
        bit is_load, mis, skip, got_pulse, b_armed, r_pend, b_pend, ar_wait, aw_wait, w_wait, exp_fault;
        int unsigned ar_n, r_n, aw_n, w_n, b_n, lat, rcnt, bcnt, since_w;
        is_load = ld;
        mis = (32'(a[1:0]) % size_of(fn)) != 0;
        skip = FAULT_EN && mis;
        got_pulse = 0; b_armed = 0; r_pend = 0; b_pend = 0;
        ar_wait = 0; aw_wait = 0; w_wait = 0;
        ar_n = 0; r_n = 0; aw_n = 0; w_n = 0; b_n = 0; lat = 0; since_w = 0;
        rcnt = (mode == 0) ? $urandom_range(0, 3) : 0;
        bcnt = (mode == 0) ? $urandom_range(0, 3) : 0;
        lsu_avalid = 1'b1; lsu_ren = ld; lsu_wen = st;
        lsu_addr = a; lsu_wdata = wd; lsu_fn = fn;
        for (int cyc = 0; cyc < 80 && !got_pulse; cyc++) begin
            @(posedge clk); #1;
            lat++;
            if (w_n != 0) since_w++;
            if (ar_wait) check("ar_hold", 32'(arvalid), 32'd1);
            if (aw_wait) check("aw_hold", 32'(awvalid), 32'd1);
            if (w_wait)  check("w_hold", 32'(wvalid), 32'd1);
            if (lsu_rvalid || lsu_wready) begin
                got_pulse = 1;
                check("rvalid_pulse", 32'(lsu_rvalid), 32'(is_load));
                check("wready_pulse", 32'(lsu_wready), 32'(!is_load));
                exp_fault = FAULT_EN && (mis || resp != 2'd0);
                check("fault", 32'(lsu_fault), 32'(exp_fault));
                if (is_load && !skip) last_rdata = model_load(word, a, fn);
                check("rdata", lsu_rdata, last_rdata);
                if (mode == 1 && !skip) check("latency", lat + 1, 32'd4);
            end
            // R channel
            if (r_pend && rcnt == 0) begin
                rvalid = 1'b1; rdata = word; rresp = resp;
                if (rready) begin r_n++; r_pend = 0; end
            end else begin
                rvalid = 1'b0; rdata = $urandom; rresp = 2'($urandom);
                if (r_pend) rcnt--;
            end
            // AR channel
            arready = (mode != 0) ? 1'b1 : 1'($urandom_range(0, 1));
            ar_wait = 0;
            if (arvalid) begin
                if (arready) begin check("araddr", araddr, a); ar_n++; r_pend = 1; end
                else ar_wait = 1;
            end
            // B channel
            if (b_pend && bcnt == 0) begin
                bvalid = 1'b1; bresp = resp;
                if (bready) begin b_n++; b_pend = 0; end
            end else begin
                bvalid = 1'b0; bresp = 2'($urandom);
                if (b_pend) bcnt--;
            end
            // AW / W channels
            case (mode)
                1: begin awready = 1'b1; wready = 1'b1; end
                2: begin wready = 1'b1; awready = (w_n != 0) && (since_w >= 3); end
                default: begin awready = 1'($urandom_range(0, 1)); wready = 1'($urandom_range(0, 1)); end
            endcase
            aw_wait = 0;
            w_wait  = 0;
            if (awvalid) begin
                if (awready) begin check("awaddr", awaddr, a); aw_n++; end
                else aw_wait = 1;
            end
            if (wvalid) begin
                if (wready) begin
                    check("wdata", wdata, model_wdata(wd, a));
                    check("wstrb", 32'(wstrb), 32'(model_strb(a, fn)));
                    w_n++;
                end else w_wait = 1;
            end
            if (!b_armed && aw_n == 1 && w_n == 1) begin b_armed = 1; b_pend = 1; end
        end
        check("pulse_seen", 32'(got_pulse), 32'd1);
        check("ar_count", ar_n, 32'(is_load && !skip));
        check("r_count",  r_n,  32'(is_load && !skip));
        check("aw_count", aw_n, 32'(!is_load && !skip));
        check("w_count",  w_n,  32'(!is_load && !skip));
        check("b_count",  b_n,  32'(!is_load && !skip));
        // avalid stays high through the pulse cycle; nothing may be re-issued
        rvalid = 1'b0; bvalid = 1'b0; arready = 1'b0; awready = 1'b0; wready = 1'b0;
        @(posedge clk); #1;
        check("pulse_width", 32'({lsu_rvalid, lsu_wready}), 32'd0);
        check("no_reissue", 32'({arvalid, awvalid, wvalid}), 32'd0);
    endtask

    task automatic reset_in_rdata();
        bit reached;
        reached = 0;
        lsu_avalid = 1'b1; lsu_ren = 1'b1; lsu_wen = 1'b0;
        lsu_addr = 32'h8000_0010; lsu_fn = 4'd2;
        arready = 1'b1; rvalid = 1'b0;
        for (int c = 0; c < 20 && !reached; c++) begin
            @(posedge clk); #1;
            if (rready) reached = 1;
        end
        check("reach_rdata", 32'(reached), 32'd1);
        rst = 1'b0;
        arready = 1'b0;
        @(posedge clk); #1;
        check_all_zero("midrst");
        last_rdata = 32'd0;
        rst = 1'b1;
        idle(4);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit ld, st;
        int unsigned r;
        logic [31:0] a;
        logic [3:0] fn;
        rst = 1'b0;
        lsu_avalid = 1'b0; lsu_ren = 1'b0; lsu_wen = 1'b0;
        lsu_addr = '0; lsu_wdata = '0; lsu_fn = '0;
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rvalid = 1'b0; rdata = '0; rresp = '0;
        bvalid = 1'b0; bresp = '0;
        last_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        do_txn(1, 0, 32'h8000_0003, 32'd0, 4'd0, 32'h8011_2233, 2'd0, 1);        // LB
        do_txn(1, 0, 32'h8000_0002, 32'd0, 4'd5, 32'hBEEF_1234, 2'd0, 0);        // LHU
        do_txn(0, 1, 32'h8000_0001, 32'h0000_00AB, 4'd0, 32'd0, 2'd0, 2);        // SB, late AW
        do_txn(1, 0, 32'h8000_0010, 32'd0, 4'd2, 32'hCAFE_F00D, 2'd0, 1);        // LW
        do_txn(0, 1, 32'h8000_0014, 32'h1234_5678, 4'd2, 32'd0, 2'd0, 1);        // next cycle SW
        do_txn(1, 1, 32'h8000_0005, 32'h0000_0055, 4'd1, 32'h7F80_AA55, 2'd0, 0); // both: load wins
        idle(2);

        // avalid without ren/wen must be ignored
        lsu_avalid = 1'b1; lsu_ren = 1'b0; lsu_wen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("no_op_req", 32'({lsu_rvalid, lsu_wready, arvalid, awvalid, wvalid}), 32'd0);
        end
        idle(1);

        for (int i = 0; i < 150; i++) begin
            r  = $urandom_range(0, 9);
            ld = (r < 4) || (r >= 8);
            st = (r >= 4);
            a  = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
            fn = 4'($urandom);
            do_txn(ld, st, a, $urandom, fn, $urandom, 2'($urandom),
                   ($urandom_range(0, 3) == 0) ? 1 : 0);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(1);

        reset_in_rdata();

`ifdef YSYX_LSU_FAULT_EN
        do_txn(1, 0, 32'h8000_0002, 32'd0, 4'd2, 32'h1111_2222, 2'd0, 1);        // misaligned LW
        do_txn(0, 1, 32'h8000_0008, 32'hDEAD_BEEF, 4'd2, 32'd0, 2'd2, 1);        // SLVERR store
        idle(1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
